// File: rtl/minhash_jaccard_engine_if.sv
// Control, coefficient and k-mer stream bundle of the MinHash engine.
// master drives config/start/abort/k-mers; slave (the engine) returns ready, busy, done, simCount.
interface minhash_jaccard_engine_if #(
  parameter int KMER_W   = 32,
  parameter int HASH_W   = 32,
  parameter int NUM_HASH = 8,
  parameter int IDX_W    = (NUM_HASH > 1) ? $clog2(NUM_HASH) : 1,
  parameter int SIM_W    = $clog2(NUM_HASH + 1)
);
  logic              cfgWe;
  logic [IDX_W-1:0]  cfgIdx;
  logic [HASH_W-1:0] cfgA;
  logic [HASH_W-1:0] cfgB;
  logic              start;
  logic              abort;
  logic              kmerValid;
  logic              kmerReady;
  logic [KMER_W-1:0] kmerSeqOne;
  logic [KMER_W-1:0] kmerSeqTwo;
  logic              busy;
  logic              done;
  logic [SIM_W-1:0]  simCount;

  modport master (
    output cfgWe, cfgIdx, cfgA, cfgB, start, abort, kmerValid, kmerSeqOne, kmerSeqTwo,
    input  kmerReady, busy, done, simCount
  );

  modport slave (
    input  cfgWe, cfgIdx, cfgA, cfgB, start, abort, kmerValid, kmerSeqOne, kmerSeqTwo,
    output kmerReady, busy, done, simCount
  );
endinterface

// File: rtl/minhash_jaccard_engine.sv
// MinHash engine: NUM_HASH affine hashes, running minima per sequence, count of agreeing minima.
// Last accept at edge T -> done after edge T+4; 1 pair/cycle, kmerReady high only while in RUN.
module minhash_jaccard_engine #(
  parameter int KMER_W    = 32,
  parameter int HASH_W    = 32,
  parameter int NUM_HASH  = 8,
  parameter int NUM_KMERS = 49,
  parameter int IDX_W     = (NUM_HASH > 1) ? $clog2(NUM_HASH) : 1,
  parameter int SIM_W     = $clog2(NUM_HASH + 1)
) (
  input logic                     clk,
  input logic                     rst,
  minhash_jaccard_engine_if.slave bus
);
  localparam int CNT_W = $clog2(NUM_KMERS + 1);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_COMPARE, S_DONE} state_t;

  state_t            r_state;
  logic [HASH_W-1:0] r_a       [NUM_HASH];
  logic [HASH_W-1:0] r_b       [NUM_HASH];
  logic [HASH_W-1:0] r_h_one   [NUM_HASH];
  logic [HASH_W-1:0] r_h_two   [NUM_HASH];
  logic [HASH_W-1:0] r_min_one [NUM_HASH];
  logic [HASH_W-1:0] r_min_two [NUM_HASH];
  logic              r_s1_vld;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_drain;
  logic              r_kmer_rdy;
  logic              r_done;
  logic [SIM_W-1:0]  r_sim;

  logic [HASH_W-1:0] w_k_one;
  logic [HASH_W-1:0] w_k_two;
  logic              w_accept;
  logic [SIM_W-1:0]  w_match_cnt;

  generate
    if (KMER_W >= HASH_W) begin : g_trunc
      assign w_k_one = bus.kmerSeqOne[HASH_W-1:0];
      assign w_k_two = bus.kmerSeqTwo[HASH_W-1:0];
    end else begin : g_zext
      assign w_k_one = {{(HASH_W-KMER_W){1'b0}}, bus.kmerSeqOne};
      assign w_k_two = {{(HASH_W-KMER_W){1'b0}}, bus.kmerSeqTwo};
    end
  endgenerate

  assign w_accept = bus.kmerValid && r_kmer_rdy;

  always_comb begin
    w_match_cnt = '0;
    for (int i = 0; i < NUM_HASH; i++) begin
      if (r_min_one[i] == r_min_two[i]) w_match_cnt = w_match_cnt + SIM_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_s1_vld   <= 1'b0;
      r_cnt      <= '0;
      r_drain    <= 1'b0;
      r_kmer_rdy <= 1'b0;
      r_done     <= 1'b0;
      r_sim      <= '0;
      for (int i = 0; i < NUM_HASH; i++) begin
        r_a[i]       <= '0;
        r_b[i]       <= '0;
        r_h_one[i]   <= '0;
        r_h_two[i]   <= '0;
        r_min_one[i] <= '1;
        r_min_two[i] <= '1;
      end
    end else begin
      r_done   <= 1'b0;
      r_s1_vld <= 1'b0;
      if (r_state != S_IDLE && bus.abort) begin
        r_state    <= S_IDLE;
        r_kmer_rdy <= 1'b0;
        r_cnt      <= '0;
        r_drain    <= 1'b0;
      end else begin
        // Stage 1 hashes the accepted pair; stage 2 folds the previous cycle's hashes into the minima.
        if (w_accept) begin
          r_s1_vld <= 1'b1;
          for (int i = 0; i < NUM_HASH; i++) begin
            r_h_one[i] <= r_a[i] * w_k_one + r_b[i];
            r_h_two[i] <= r_a[i] * w_k_two + r_b[i];
          end
        end
        if (r_s1_vld) begin
          for (int i = 0; i < NUM_HASH; i++) begin
            if (r_h_one[i] < r_min_one[i]) r_min_one[i] <= r_h_one[i];
            if (r_h_two[i] < r_min_two[i]) r_min_two[i] <= r_h_two[i];
          end
        end
        case (r_state)
          S_IDLE: begin
            for (int i = 0; i < NUM_HASH; i++) begin
              if (bus.cfgWe && bus.cfgIdx == IDX_W'(i)) begin
                r_a[i] <= bus.cfgA;
                r_b[i] <= bus.cfgB;
              end
            end
            if (bus.start) begin
              r_state    <= S_RUN;
              r_kmer_rdy <= 1'b1;
              r_cnt      <= '0;
              for (int i = 0; i < NUM_HASH; i++) begin
                r_min_one[i] <= '1;
                r_min_two[i] <= '1;
              end
            end
          end
          S_RUN: begin
            if (w_accept) begin
              r_cnt <= r_cnt + CNT_W'(1);
              if (r_cnt == CNT_W'(NUM_KMERS - 1)) begin
                r_state    <= S_DRAIN;
                r_kmer_rdy <= 1'b0;
                r_drain    <= 1'b0;
              end
            end
          end
          S_DRAIN: begin
            r_drain <= 1'b1;
            if (r_drain) r_state <= S_COMPARE;
          end
          S_COMPARE: begin
            r_sim   <= w_match_cnt;
            r_state <= S_DONE;
          end
          S_DONE: begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.kmerReady = r_kmer_rdy;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = r_done;
  assign bus.simCount  = r_sim;
endmodule

// File: tb/tb_minhash_jaccard_engine.sv
// Directed bench for minhash_jaccard_engine with NUM_HASH=4, NUM_KMERS=4.
module tb_minhash_jaccard_engine;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_bad;

  logic [31:0] seq1 [4];
  logic [31:0] seq2 [4];
  logic [31:0] c_a  [4];
  logic [31:0] c_b  [4];

  minhash_jaccard_engine_if #(.KMER_W(32), .HASH_W(32), .NUM_HASH(4)) bus ();

  minhash_jaccard_engine #(
    .KMER_W(32), .HASH_W(32), .NUM_HASH(4), .NUM_KMERS(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Reference: min over the sequence of (a*x+b) mod 2^32, count agreeing minima.
  function automatic int ref_sim();
    logic [31:0] m1, m2, t;
    int s;
    s = 0;
    for (int h = 0; h < 4; h++) begin
      m1 = '1;
      m2 = '1;
      for (int j = 0; j < 4; j++) begin
        t = c_a[h] * seq1[j] + c_b[h];
        if (t < m1) m1 = t;
        t = c_a[h] * seq2[j] + c_b[h];
        if (t < m2) m2 = t;
      end
      if (m1 == m2) s++;
    end
    return s;
  endfunction

  task automatic wr_cfg(input int idx, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.cfgWe  = 1'b1;
    bus.cfgIdx = 2'(idx);
    bus.cfgA   = a;
    bus.cfgB   = b;
    c_a[idx]   = a;
    c_b[idx]   = b;
    @(negedge clk);
    bus.cfgWe = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic feed(input logic [15:0] vpat, input int vlen, input int start_at,
                      input int stop_at, input bit do_abort, output int n_acc);
    int idx, p, guard;
    logic v;
    idx = 0; p = 0; guard = 0;
    while (idx < 4 && guard < 64) begin
      bus.kmerSeqOne = seq1[idx];
      bus.kmerSeqTwo = seq2[idx];
      if (idx == stop_at) begin
        if (do_abort) begin
          bus.abort     = 1'b1;
          bus.kmerValid = 1'b1;
          @(negedge clk);
          bus.abort = 1'b0;
        end
        break;
      end
      v = (p < vlen) ? vpat[p] : 1'b1;
      bus.kmerValid = v;
      bus.start     = (idx == start_at);
      if (v && bus.kmerReady) idx++;
      p++;
      guard++;
      @(negedge clk);
    end
    bus.kmerValid = 1'b0;
    bus.start     = 1'b0;
    n_acc = idx;
  endtask

  task automatic check_done(input string tag, input int exp_sim);
    int k;
    chk({tag, "_rdy_drain"}, bus.kmerReady, 0);
    chk({tag, "_busy_drain"}, bus.busy, 1);
    k = 0;
    while (!bus.done && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_latency"}, k, 4);
    chk({tag, "_sim"}, bus.simCount, exp_sim);
    @(negedge clk);
    chk({tag, "_done_pulse"}, bus.done, 0);
    chk({tag, "_busy_end"}, bus.busy, 0);
  endtask

  initial begin
    int n, seen;
    n_chk = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.cfgWe = 0; bus.cfgIdx = 0; bus.cfgA = 0; bus.cfgB = 0;
    bus.start = 0; bus.abort = 0; bus.kmerValid = 0;
    bus.kmerSeqOne = 0; bus.kmerSeqTwo = 0;
    for (int i = 0; i < 4; i++) begin c_a[i] = 0; c_b[i] = 0; end
    #3;
    chk("rst_rdy", bus.kmerReady, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_sim", bus.simCount, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_rdy", bus.kmerReady, 0);

    // Test 1: mixed coefficients, minima (3,3),(2^32-9,2^32-10),(8,8),(7,7)
    wr_cfg(0, 32'd1, 32'd0);
    wr_cfg(1, 32'hFFFF_FFFF, 32'd0);
    wr_cfg(2, 32'd1, 32'd5);
    wr_cfg(3, 32'd0, 32'd7);
    seq1 = '{32'd5, 32'd9, 32'd3, 32'd7};
    seq2 = '{32'd8, 32'd3, 32'd6, 32'd10};
    pulse_start();
    chk("t1_busy_run", bus.busy, 1);
    chk("t1_rdy_run", bus.kmerReady, 1);
    feed(16'h0, 0, -1, -1, 1'b0, n);
    chk("t1_accepts", n, 4);
    check_done("t1", 3);

    // Test 2: identical sequences
    seq1 = '{32'd1, 32'd2, 32'd3, 32'd4};
    seq2 = '{32'd1, 32'd2, 32'd3, 32'd4};
    pulse_start();
    feed(16'h0, 0, -1, -1, 1'b0, n);
    chk("t2_accepts", n, 4);
    check_done("t2", 4);

    // Test 3: wrap-around, 2*0x80000001 -> 2; last coefficient written in the start cycle
    wr_cfg(0, 32'd2, 32'd0);
    wr_cfg(1, 32'd1, 32'd0);
    wr_cfg(2, 32'd3, 32'd1);
    seq1 = '{32'h8000_0001, 32'hF000_0000, 32'hE000_0000, 32'hD000_0000};
    seq2 = '{32'h0000_0001, 32'hF000_0000, 32'hE000_0000, 32'hD000_0000};
    @(negedge clk);
    bus.start  = 1'b1;
    bus.cfgWe  = 1'b1;
    bus.cfgIdx = 2'd3;
    bus.cfgA   = 32'd0;
    bus.cfgB   = 32'd0;
    c_a[3] = 0; c_b[3] = 0;
    @(negedge clk);
    bus.start = 1'b0;
    bus.cfgWe = 1'b0;
    feed(16'h0, 0, -1, -1, 1'b0, n);
    chk("t3_accepts", n, 4);
    check_done("t3", ref_sim());

    // Test 4: stalls on kmerValid 1,0,0,1,1,0,1 with test-1 data
    wr_cfg(0, 32'd1, 32'd0);
    wr_cfg(1, 32'hFFFF_FFFF, 32'd0);
    wr_cfg(2, 32'd1, 32'd5);
    wr_cfg(3, 32'd0, 32'd7);
    seq1 = '{32'd5, 32'd9, 32'd3, 32'd7};
    seq2 = '{32'd8, 32'd3, 32'd6, 32'd10};
    pulse_start();
    feed(16'b1011001, 7, -1, -1, 1'b0, n);
    chk("t4_accepts", n, 4);
    check_done("t4", 3);

    // Test 5: abort after 2 accepts, then clean runs; start mid-RUN ignored
    pulse_start();
    feed(16'h0, 0, -1, 2, 1'b1, n);
    chk("t5_abort_accepts", n, 2);
    chk("t5_abort_busy", bus.busy, 0);
    chk("t5_abort_rdy", bus.kmerReady, 0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done) seen++;
      @(negedge clk);
    end
    chk("t5_abort_no_done", seen, 0);
    chk("t5_abort_sim_hold", bus.simCount, 3);
    seq1 = '{32'd1, 32'd2, 32'd3, 32'd4};
    seq2 = '{32'd1, 32'd2, 32'd3, 32'd4};
    pulse_start();
    feed(16'h0, 0, -1, -1, 1'b0, n);
    check_done("t5b", 4);
    seq1 = '{32'd5, 32'd9, 32'd3, 32'd7};
    seq2 = '{32'd8, 32'd3, 32'd6, 32'd10};
    pulse_start();
    feed(16'h0, 0, 2, -1, 1'b0, n);
    chk("t5c_accepts", n, 4);
    check_done("t5c", 3);

    // Test 6a: cfgWe during RUN ignored (would make hash 1 agree)
    pulse_start();
    bus.cfgWe  = 1'b1;
    bus.cfgIdx = 2'd1;
    bus.cfgA   = 32'd1;
    bus.cfgB   = 32'd0;
    @(negedge clk);
    bus.cfgWe = 1'b0;
    feed(16'h0, 0, -1, -1, 1'b0, n);
    check_done("t6a", 3);

    // Test 6b: async reset mid-RUN clears outputs and coefficients
    pulse_start();
    feed(16'h0, 0, -1, 2, 1'b0, n);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_rdy", bus.kmerReady, 0);
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_sim", bus.simCount, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulse_start();
    feed(16'h0, 0, -1, -1, 1'b0, n);
    chk("t6b_accepts", n, 4);
    check_done("t6b", 4);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
